// File: rtl/delay_line_pkg.sv
// Shared types and helpers for the programmable delay line: delay clamping,
// pointer sizing and the default-shape channel bus type.
package delay_line_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32'd8;
    localparam int unsigned DEF_NUM_CH     = 32'd1;

    typedef logic [DEF_NUM_CH-1:0][DEF_DATA_WIDTH-1:0] ch_bus_t;

    function automatic int unsigned ptr_width(input int unsigned max_dly);
        return (max_dly <= 32'd1) ? 32'd1 : $clog2(max_dly);
    endfunction

    function automatic int unsigned clamp_dly(input int unsigned req, input int unsigned max_dly);
        if (req == 32'd0) begin
            return 32'd1;
        end else if (req > max_dly) begin
            return max_dly;
        end else begin
            return req;
        end
    endfunction

endpackage

// File: rtl/delay_line_ptr.sv
// Modulo-MAX_VAL wrapping pointer with beat enable and synchronous clear.
module delay_line_ptr
#(
    parameter int unsigned MAX_VAL = 16,
    parameter int unsigned PTR_W   = 4
)(
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Next pointer: clear wins, otherwise advance and wrap at MAX_VAL-1.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (en_i) begin
            if (ptr_q == PTR_W'(MAX_VAL - 32'd1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + PTR_W'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/delay_line_prog.sv
// Runtime-programmable, stallable, valid-tagged circular-buffer delay line.
// Define DELAY_LINE_PROG_DATA_RESET_EN to reset the data path and zero data_o while invalid.
module delay_line_prog
    import delay_line_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_CH     = 1,
    parameter int unsigned MAX_DELAY  = 16,
    parameter int unsigned DLY_W      = $clog2(MAX_DELAY + 1)
)(
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         en_i,
    input  logic                         flush_i,
    input  logic                         dly_we_i,
    input  logic [DLY_W-1:0]             dly_i,
    input  logic                         valid_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_i,
    output logic                         valid_o,
    output logic [NUM_CH*DATA_WIDTH-1:0] data_o,
    output logic                         primed_o,
    output logic [DLY_W-1:0]             dly_o
);

    localparam int unsigned PTR_W = ptr_width(MAX_DELAY);
    localparam int unsigned BUS_W = NUM_CH * DATA_WIDTH;
    localparam int unsigned SUM_W = DLY_W + 1;

    logic             clr_s;
    logic             beat_s;
    logic [PTR_W-1:0] wr_ptr_s;
    logic [PTR_W-1:0] rd_idx_s;
    logic [SUM_W-1:0] rd_sum_s;

    logic [DLY_W-1:0] dly_q, dly_d;
    logic [DLY_W-1:0] cnt_q, cnt_d;
    logic             primed_q, primed_d;
    logic             valid_q, valid_d;
    logic [BUS_W-1:0] data_q, data_d;

    logic [MAX_DELAY-1:0] vmem_q;
    logic [BUS_W-1:0]     dmem_q [MAX_DELAY];

    // Reload and flush both discard in-flight samples, even during a stall.
    assign clr_s  = flush_i | dly_we_i;
    assign beat_s = en_i & ~clr_s;

    delay_line_ptr #(
        .MAX_VAL (MAX_DELAY),
        .PTR_W   (PTR_W)
    ) u_wr_ptr (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (beat_s),
        .clr_i   (clr_s),
        .ptr_o   (wr_ptr_s)
    );

    // Read index (wr - D) mod MAX_DELAY, biased by MAX_DELAY to stay non-negative.
    always_comb begin
        rd_sum_s = SUM_W'(wr_ptr_s) + SUM_W'(MAX_DELAY) - SUM_W'(dly_q);
        if (rd_sum_s >= SUM_W'(MAX_DELAY)) begin
            rd_idx_s = PTR_W'(rd_sum_s - SUM_W'(MAX_DELAY));
        end else begin
            rd_idx_s = PTR_W'(rd_sum_s);
        end
    end

    // Next-state for delay, primed counter and output stage.
    always_comb begin
        dly_d    = dly_q;
        cnt_d    = cnt_q;
        primed_d = primed_q;
        valid_d  = valid_q;
        data_d   = data_q;
        if (dly_we_i) begin
            dly_d = DLY_W'(clamp_dly(32'(dly_i), MAX_DELAY));
        end else begin
            dly_d = dly_q;
        end
        if (clr_s) begin
            cnt_d    = '0;
            primed_d = 1'b0;
            valid_d  = 1'b0;
`ifdef DELAY_LINE_PROG_DATA_RESET_EN
            data_d   = '0;
`endif
        end else if (en_i) begin
            primed_d = (cnt_q == dly_q);
            if (cnt_q == dly_q) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + DLY_W'(1);
            end
            valid_d = vmem_q[rd_idx_s];
`ifdef DELAY_LINE_PROG_DATA_RESET_EN
            if (vmem_q[rd_idx_s]) begin
                data_d = dmem_q[rd_idx_s];
            end else begin
                data_d = '0;
            end
`else
            data_d = dmem_q[rd_idx_s];
`endif
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dly_q    <= DLY_W'(MAX_DELAY);
            cnt_q    <= '0;
            primed_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            dly_q    <= dly_d;
            cnt_q    <= cnt_d;
            primed_q <= primed_d;
            valid_q  <= valid_d;
        end
    end

    // Per-slot valid tags; a clear invalidates every slot at once.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vmem_q <= '0;
        end else if (clr_s) begin
            vmem_q <= '0;
        end else if (beat_s) begin
            vmem_q[wr_ptr_s] <= valid_i;
        end
    end

`ifdef DELAY_LINE_PROG_DATA_RESET_EN
    // Resettable data storage and output register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q <= '0;
            for (int unsigned i = 0; i < MAX_DELAY; i++) begin
                dmem_q[i] <= '0;
            end
        end else begin
            data_q <= data_d;
            if (beat_s) begin
                dmem_q[wr_ptr_s] <= data_i;
            end
        end
    end
`else
    // Reset-free data storage so it can map onto RAM.
    always_ff @(posedge clk_i) begin
        data_q <= data_d;
        if (beat_s) begin
            dmem_q[wr_ptr_s] <= data_i;
        end
    end
`endif

    assign valid_o  = valid_q;
    assign data_o   = data_q;
    assign primed_o = primed_q;
    assign dly_o    = dly_q;

endmodule
